// File: rtl/memctl_pkg.sv
// memctl_pkg: shared constants, types and helpers for memory_controller.
//   - I/O window offsets (TX_DATA, STATUS, RX_DATA) relative to IO_BASE
//   - STATUS register bit positions and a packing helper
//   - TX queue depth: 4 entries when MEMCTL_TX_FIFO_EN is defined,
//     otherwise a single holding register
//   - address region type and a decode helper
package memctl_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] IO_OFS_TX_DATA = 24'd0;
  localparam logic [ADDR_W-1:0] IO_OFS_STATUS  = 24'd1;
  localparam logic [ADDR_W-1:0] IO_OFS_RX_DATA = 24'd2;

  localparam int ST_BIT_TX_FULL    = 0;
  localparam int ST_BIT_RX_VALID   = 1;
  localparam int ST_BIT_TX_OVERFLOW = 2;
  localparam int ST_BIT_RX_OVERRUN = 3;

`ifdef MEMCTL_TX_FIFO_EN
  localparam int TX_DEPTH = 4;
`else
  localparam int TX_DEPTH = 1;
`endif

  typedef enum logic [2:0] {
    REGION_NONE,
    REGION_RAM,
    REGION_TX,
    REGION_STATUS,
    REGION_RX
  } region_e;

  // RAM takes priority if a misconfigured IO_BASE overlaps the RAM range.
  function automatic region_e decode_region(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] ram_words,
    input logic [ADDR_W-1:0] io_base
  );
    region_e region;
    if (addr < ram_words)                        region = REGION_RAM;
    else if (addr == io_base + IO_OFS_TX_DATA)   region = REGION_TX;
    else if (addr == io_base + IO_OFS_STATUS)    region = REGION_STATUS;
    else if (addr == io_base + IO_OFS_RX_DATA)   region = REGION_RX;
    else                                         region = REGION_NONE;
    return region;
  endfunction

  function automatic logic [DATA_W-1:0] pack_status(
    input logic rx_overrun,
    input logic tx_overflow,
    input logic rx_valid,
    input logic tx_full
  );
    logic [DATA_W-1:0] word;
    word = '0;
    word[ST_BIT_RX_OVERRUN]  = rx_overrun;
    word[ST_BIT_TX_OVERFLOW] = tx_overflow;
    word[ST_BIT_RX_VALID]    = rx_valid;
    word[ST_BIT_TX_FULL]     = tx_full;
    return word;
  endfunction

endpackage

// File: rtl/memctl_fifo.sv
// memctl_fifo: synchronous FIFO used as the TX queue.
// Ports:
//   clk, srst          clock and synchronous active-high reset
//   push, push_data    write request and data
//   pop                read request (ignored while empty)
//   pop_data           head entry, forced to zero while empty
//   full, empty, count occupancy; count is one bit wider than the pointers
//   overflow           one-cycle pulse when a push is dropped
// A push to a full queue is accepted if a pop happens in the same cycle,
// since the pop frees the slot the push needs.
module memctl_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 16,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             do_push, do_pop;
  logic [DEPTH-1:0][WIDTH-1:0] slot_data;

  // Explicit wrap so non-power-of-two depths (and depth 1) stay in range.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign count    = count_reg;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_push) wr_ptr_next = bump(wr_ptr_reg);
    if (do_pop)  rd_ptr_next = bump(rd_ptr_reg);
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage slots carry no reset; stale contents are never visible because
  // pop_data is masked while empty.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [WIDTH-1:0] slot_reg;
      always_ff @(posedge clk) begin
        if (!srst && do_push && (wr_ptr_reg == PTR_W'(gi))) begin
          slot_reg <= push_data;
        end
      end
      assign slot_data[gi] = slot_reg;
    end
  endgenerate

  always_comb begin
    pop_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!empty && (rd_ptr_reg == PTR_W'(i))) pop_data = slot_data[i];
    end
  end

endmodule

// File: rtl/memory_controller.sv
// memory_controller: core-side memory with a RAM region and a small I/O
// register window (TX_DATA, STATUS, RX_DATA at IO_BASE+0/1/2).
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   core_to_mem_addr/data/write_enable core word address, write data, write level
//   mem_to_core_data                   read data, one cycle after the address
//   io_out_data/valid/ready            TX queue head toward the peripheral
//   io_in_data/valid                   RX capture from the peripheral
// Build option: define MEMCTL_TX_FIFO_EN for a 4-deep TX queue; without it
// the queue is a single holding register.
module memory_controller
  import memctl_pkg::*;
#(
  parameter int               RAM_WORDS = 4096,
  parameter logic [ADDR_W-1:0] IO_BASE  = 24'hFFFF00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] core_to_mem_addr,
  input  logic [DATA_W-1:0] core_to_mem_data,
  input  logic              core_to_mem_write_enable,
  output logic [DATA_W-1:0] mem_to_core_data,
  output logic [DATA_W-1:0] io_out_data,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  input  logic [DATA_W-1:0] io_in_data,
  input  logic              io_in_valid
);

  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int TX_CNT_W = ((TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1) + 1;

  // ---------------------------------------------------------------- decode
  region_e            region;
  logic [ADDR_W-1:0]  prev_addr_reg;
  logic               prev_we_reg;
  logic               addr_changed;
  logic               wr_strobe;
  logic               rd_strobe;

  assign region       = decode_region(core_to_mem_addr, ADDR_W'(RAM_WORDS), IO_BASE);
  assign addr_changed = (core_to_mem_addr != prev_addr_reg);
  // The core holds write_enable for several cycles per store; only the
  // first cycle (or a new address) counts as a write.
  assign wr_strobe    = core_to_mem_write_enable && (!prev_we_reg || addr_changed);
  // Reads have side effects on I/O registers, so they fire once on arrival.
  assign rd_strobe    = addr_changed;

  logic ram_wr, tx_push, status_rd, rx_rd;
  assign ram_wr    = wr_strobe && (region == REGION_RAM);
  assign tx_push   = wr_strobe && (region == REGION_TX) && !reset;
  assign status_rd = rd_strobe && (region == REGION_STATUS);
  assign rx_rd     = rd_strobe && (region == REGION_RX);

  // ------------------------------------------------------------------- RAM
  // Written even during reset so a store in flight is not lost; contents
  // survive reset.
  logic [DATA_W-1:0] ram_mem [RAM_WORDS];
  logic [DATA_W-1:0] ram_q_reg;
  logic [RAM_AW-1:0] ram_addr;

  assign ram_addr = core_to_mem_addr[RAM_AW-1:0];

  always_ff @(posedge clk) begin
    if (ram_wr) ram_mem[ram_addr] <= core_to_mem_data;
    ram_q_reg <= ram_mem[ram_addr];
  end

  // -------------------------------------------------------------- TX queue
  logic [DATA_W-1:0]   tx_head;
  logic                tx_full, tx_empty, tx_overflow_evt, tx_pop;
  logic [TX_CNT_W-1:0] tx_count;
  logic                unused_tx_count;

  // Valid is masked during reset so the peripheral never sees a pop there.
  assign io_out_valid    = !tx_empty && !reset;
  assign io_out_data     = tx_head;
  assign tx_pop          = io_out_valid && io_out_ready;
  assign unused_tx_count = ^tx_count;

  memctl_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (DATA_W)
  ) u_tx_fifo (
    .clk       (clk),
    .srst      (reset),
    .push      (tx_push),
    .push_data (core_to_mem_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count),
    .overflow  (tx_overflow_evt)
  );

  // ------------------------------------------------------ RX and status
  logic [DATA_W-1:0] rx_data_reg, rx_data_next;
  logic              rx_valid_reg, rx_valid_next;
  logic              rx_overrun_reg, rx_overrun_next;
  logic              tx_overflow_reg, tx_overflow_next;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] io_rd_reg, io_rd_next;
  region_e           region_q_reg;

  assign status_word = pack_status(rx_overrun_reg, tx_overflow_reg, rx_valid_reg, tx_full);

  always_comb begin
    rx_data_next     = rx_data_reg;
    rx_valid_next    = rx_valid_reg;
    rx_overrun_next  = rx_overrun_reg;
    tx_overflow_next = tx_overflow_reg;
    io_rd_next       = '0;

    case (region)
      REGION_STATUS: io_rd_next = status_word;
      REGION_RX:     io_rd_next = rx_data_reg;
      default:       io_rd_next = '0;
    endcase

    // Clears first, then new events, so an event coincident with the
    // clearing read is never lost.
    if (status_rd) begin
      rx_overrun_next  = 1'b0;
      tx_overflow_next = 1'b0;
    end
    if (rx_rd) rx_valid_next = 1'b0;

    if (io_in_valid) begin
      rx_data_next  = io_in_data;
      rx_valid_next = 1'b1;
      if (rx_valid_reg) rx_overrun_next = 1'b1;
    end
    if (tx_overflow_evt) tx_overflow_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_addr_reg   <= '0;
      prev_we_reg     <= 1'b0;
      region_q_reg    <= REGION_NONE;
      io_rd_reg       <= '0;
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      rx_overrun_reg  <= 1'b0;
      tx_overflow_reg <= 1'b0;
    end else begin
      prev_addr_reg   <= core_to_mem_addr;
      prev_we_reg     <= core_to_mem_write_enable;
      region_q_reg    <= region;
      io_rd_reg       <= io_rd_next;
      rx_data_reg     <= rx_data_next;
      rx_valid_reg    <= rx_valid_next;
      rx_overrun_reg  <= rx_overrun_next;
      tx_overflow_reg <= tx_overflow_next;
    end
  end

  // Both paths are registered; the mux only selects which one was addressed.
  assign mem_to_core_data = (region_q_reg == REGION_RAM) ? ram_q_reg : io_rd_reg;

endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: scoreboard bench for memory_controller.
// Read expectations are queued when an address is driven and compared when
// the read data appears; TX expectations are queued on push and compared
// on each peripheral pop.
module tb_memory_controller;

`ifdef MEMCTL_TX_FIFO_EN
  localparam int TX_D = 4;
`else
  localparam int TX_D = 1;
`endif

  localparam logic [23:0] IO_BASE = 24'hFFFF00;
  localparam logic [23:0] A_TX    = IO_BASE + 24'd0;
  localparam logic [23:0] A_ST    = IO_BASE + 24'd1;
  localparam logic [23:0] A_RX    = IO_BASE + 24'd2;

  logic        clk;
  logic        rst;
  logic [23:0] addr;
  logic [15:0] wdata;
  logic        we;
  logic [15:0] rdata;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] in_data;
  logic        in_valid;

  int checks;
  int errors;

  logic [15:0] exp_q[$];
  string       tag_q[$];
  logic [15:0] tx_exp[$];

  memory_controller #(
    .RAM_WORDS (4096),
    .IO_BASE   (IO_BASE)
  ) dut (
    .clk                      (clk),
    .reset                    (rst),
    .core_to_mem_addr         (addr),
    .core_to_mem_data         (wdata),
    .core_to_mem_write_enable (we),
    .mem_to_core_data         (rdata),
    .io_out_data              (out_data),
    .io_out_valid             (out_valid),
    .io_out_ready             (out_ready),
    .io_in_data               (in_data),
    .io_in_valid              (in_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One bus cycle. Inputs change 1 time unit after a rising edge; pops are
  // judged just before the edge and read data just after it.
  task automatic step(input logic [23:0] a, input logic [15:0] d, input logic w,
                      input logic rdy, input logic iv, input logic [15:0] id,
                      input logic chk, input logic [15:0] exp, input string tag);
    logic [15:0] e;
    string       t;
    addr = a; wdata = d; we = w; out_ready = rdy; in_valid = iv; in_data = id;
    if (chk) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    #1;
    if (rst) check_val("rst_no_valid", 16'(out_valid), 16'h0000);
    if (!rst && out_valid && rdy) begin
      if (tx_exp.size() == 0) check_val("tx_unexpected_pop", 16'(out_valid), 16'h0000);
      else                    check_val("tx_pop_data", out_data, tx_exp.pop_front());
    end
    @(posedge clk);
    #1;
    $display("txn addr=%h we=%0b wdata=%h rdy=%0b iv=%0b rdata=%h", a, w, d, rdy, iv, rdata);
    if (chk) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val(t, rdata, e);
    end
  endtask

  task automatic rd(input logic [23:0] a, input logic [15:0] exp, input string tag);
    step(a, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, exp, tag);
  endtask

  task automatic idle(input logic [23:0] a, input logic rdy);
    step(a, 16'h0, 1'b0, rdy, 1'b0, 16'h0, 1'b0, 16'h0, "");
  endtask

  // One store to TX_DATA followed by a release; the queue model admits the
  // word only while fewer than TX_D words are waiting.
  task automatic push_tx(input logic [15:0] v);
    if (tx_exp.size() < TX_D) tx_exp.push_back(v);
    step(A_TX, v, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "");
    step(A_TX, v, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "");
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; addr = '0; wdata = '0; we = 1'b0;
    out_ready = 1'b0; in_data = '0; in_valid = 1'b0;

    idle(24'h0, 1'b0);
    idle(24'h0, 1'b0);
    rst = 1'b0;
    #1;
    check_val("rst_rdata", rdata, 16'h0000);
    check_val("rst_out_valid", 16'(out_valid), 16'h0000);
    check_val("rst_out_data", out_data, 16'h0000);

    // RAM write/read, top RAM word, unmapped and write-only reads.
    step(24'h000010, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "");
    rd(24'h000010, 16'hBEEF, "ram_rd_after_wr");
    rd(24'h001000, 16'h0000, "unmapped_above_ram");
    step(24'h000FFF, 16'h1111, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "");
    rd(24'h000FFF, 16'h1111, "ram_last_word");
    rd(IO_BASE + 24'd3, 16'h0000, "unmapped_io");
    rd(A_TX, 16'h0000, "tx_data_reads_zero");
    step(A_ST, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, "status_write_ignored");
    rd(24'h000010, 16'hBEEF, "ram_still_beef");

    // A held write_enable is one store.
    tx_exp.push_back(16'h0041);
    for (int i = 0; i < 3; i++) step(A_TX, 16'h0041, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "");
    check_val("hold_we_valid", 16'(out_valid), 16'h0001);
    check_val("hold_we_data", out_data, 16'h0041);
    rd(A_ST, (TX_D == 1) ? 16'h0001 : 16'h0000, "hold_we_status");
    idle(A_ST, 1'b1);
    check_val("hold_we_single_entry", 16'(out_valid), 16'h0000);

    // Overfill, drain in order, then sticky clear.
    for (int i = 1; i <= 5; i++) push_tx(16'(i));
    rd(A_ST, 16'h0005, "overflow_status");
    for (int i = 0; i < TX_D; i++) idle(A_ST, 1'b1);
    check_val("overflow_drained", 16'(out_valid), 16'h0000);
    rd(24'h000010, 16'hBEEF, "ram_between");
    rd(A_ST, 16'h0000, "status_cleared");

    // Push into a full queue while it pops.
    for (int i = 0; i < TX_D; i++) push_tx(16'h0011 + 16'(i));
    tx_exp.push_back(16'h0009);
    step(A_TX, 16'h0009, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, "");
    step(A_TX, 16'h0009, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "");
    rd(A_ST, 16'h0001, "full_push_pop_status");
    for (int i = 0; i < TX_D; i++) idle(A_ST, 1'b1);
    check_val("full_push_pop_drained", 16'(out_valid), 16'h0000);
    check_val("tx_model_empty", 16'(tx_exp.size()), 16'h0000);

    // RX capture, overrun, read-clear and coincident capture.
    step(24'h000010, 16'h0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h0, "");
    step(24'h000010, 16'h0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h0, "");
    rd(A_ST, 16'h000A, "rx_overrun_status");
    rd(A_RX, 16'h1234, "rx_data_read");
    rd(A_ST, 16'h0000, "rx_valid_cleared");
    step(A_RX, 16'h0, 1'b0, 1'b0, 1'b1, 16'h5678, 1'b1, 16'h1234, "rx_read_coincident");
    rd(A_ST, 16'h0002, "rx_new_data_wins");
    rd(A_RX, 16'h5678, "rx_new_data");
    step(24'h000010, 16'h0, 1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0, 16'h0, "");

    // Reset mid-operation: queue discarded, RAM store during reset kept,
    // I/O store during reset dropped.
    push_tx(16'h0031);
    push_tx(16'h0032);
    push_tx(16'h0033);
    check_val("pre_reset_valid", 16'(out_valid), 16'h0001);
    rst = 1'b1;
    step(24'h000020, 16'h7777, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, "");
    step(A_TX, 16'h0055, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, "");
    rst = 1'b0;
    tx_exp.delete();
    #1;
    check_val("post_reset_valid", 16'(out_valid), 16'h0000);
    check_val("post_reset_rdata", rdata, 16'h0000);
    rd(A_ST, 16'h0000, "post_reset_status");
    check_val("post_reset_tx_dropped", 16'(out_valid), 16'h0000);
    rd(24'h000010, 16'hBEEF, "ram_survives_reset");
    rd(24'h000020, 16'h7777, "ram_write_in_reset");
    check_val("scoreboard_empty", 16'(exp_q.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
